// File: rtl/dac_transmision_if.sv
// -----------------------------------------------------------------------------
// dac_transmision_if
//   Bundle between the sample datapath, the DAC serial transmitter and the DAC
//   pins.
//   master : the transmitter side. It takes the request, control and data, and
//            drives the status signals and the DAC pins.
//   slave  : the requester/DAC side, with the directions reversed.
//   Signals: tx_start, ctrl_in[3:0], data_in[11:0]   request
//            busy, tx_done_tick                      status
//            CS, SCLK, SDATA                         DAC serial pins
//            LDAC_n                                  only when DAC_LDAC_EN is defined
// -----------------------------------------------------------------------------
interface dac_transmision_if;
  logic        tx_start;
  logic [3:0]  ctrl_in;
  logic [11:0] data_in;
  logic        busy;
  logic        tx_done_tick;
  logic        CS;
  logic        SCLK;
  logic        SDATA;
`ifdef DAC_LDAC_EN
  logic        LDAC_n;

  modport master (
    input  tx_start, ctrl_in, data_in,
    output busy, tx_done_tick, CS, SCLK, SDATA, LDAC_n
  );
  modport slave (
    output tx_start, ctrl_in, data_in,
    input  busy, tx_done_tick, CS, SCLK, SDATA, LDAC_n
  );
`else
  modport master (
    input  tx_start, ctrl_in, data_in,
    output busy, tx_done_tick, CS, SCLK, SDATA
  );
  modport slave (
    output tx_start, ctrl_in, data_in,
    input  busy, tx_done_tick, CS, SCLK, SDATA
  );
`endif
endinterface

// File: rtl/dac_transmision.sv
// -----------------------------------------------------------------------------
// dac_transmision
//   SPI-style serial transmitter for a 16-bit DAC. A one-cycle tx_start
//   accepted while idle sends {ctrl_in, data_in} MSB first. CS is active low.
//   SCLK idles high. SDATA changes on rising SCLK, so the receiver can sample
//   on the falling edge.
//   Ports: clk, reset_n (async, active low), bus (dac_transmision_if.master)
//   Parameters: CLK_DIV        (clk cycles per SCLK half period, >= 2)
//               CS_IDLE_CYCLES (minimum CS-high cycles between frames, >= 1)
//   Optional: `define DAC_LDAC_EN adds an LDAC_n strobe. LDAC_n is low for the
//             first CLK_DIV cycles after CS rises, and the idle tail is
//             lengthened by CLK_DIV cycles.
//   All outputs are registered.
// -----------------------------------------------------------------------------
module dac_transmision #(
  parameter int CLK_DIV        = 4,
  parameter int CS_IDLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  dac_transmision_if.master bus
);

`ifdef DAC_LDAC_EN
  localparam int FIN_LEN = CLK_DIV + CS_IDLE_CYCLES;
`else
  localparam int FIN_LEN = CS_IDLE_CYCLES;
`endif
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int FIN_W = $clog2(FIN_LEN + 1);

  typedef enum logic [1:0] {INICIO, ARRANQUE, ENVIO, FIN} state_t;

  state_t            state_q;
  logic [14:0]       shift_q;   // bits still to send after the current SDATA bit
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        bit_q;     // index of the bit on SDATA, 0..15
  logic              last_q;    // rising edge after falling edge 16 has happened
  logic [FIN_W-1:0]  fin_q;
  logic              cs_q;
  logic              sclk_q;
  logic              sdata_q;
  logic              busy_q;
  logic              tick_q;
`ifdef DAC_LDAC_EN
  logic              ldac_q;
`endif

  logic div_end;
  logic fin_end;
  logic fin_pre;

  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign fin_end = (fin_q == FIN_W'(FIN_LEN - 1));
  // Registered tick must be set one edge early so that it lands on the last
  // FIN cycle.
  assign fin_pre = (int'(fin_q) == FIN_LEN - 2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INICIO;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      last_q  <= 1'b0;
      fin_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      sdata_q <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
`ifdef DAC_LDAC_EN
      ldac_q  <= 1'b1;
`endif
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        INICIO: begin
          cs_q   <= 1'b1;
          sclk_q <= 1'b1;
          if (bus.tx_start && !busy_q) begin
            shift_q <= {bus.ctrl_in[2:0], bus.data_in};
            sdata_q <= bus.ctrl_in[3];
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
            last_q  <= 1'b0;
            state_q <= ARRANQUE;
          end
        end

        // CS setup time before the first falling SCLK edge.
        ARRANQUE: begin
          if (div_end) begin
            div_q   <= '0;
            sclk_q  <= 1'b0;
            state_q <= ENVIO;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        ENVIO: begin
          if (div_end) begin
            div_q <= '0;
            if (!sclk_q) begin
              // Rising edge. Move to the next bit, or mark the frame
              // complete after bit 0 has been clocked out.
              sclk_q <= 1'b1;
              if (bit_q == 4'd15) begin
                last_q <= 1'b1;
              end else begin
                sdata_q <= shift_q[14];
                shift_q <= {shift_q[13:0], 1'b0};
                bit_q   <= bit_q + 4'd1;
              end
            end else if (last_q) begin
              // One half period after the final rising edge: release CS.
              cs_q    <= 1'b1;
              sdata_q <= 1'b0;
              fin_q   <= '0;
              tick_q  <= (FIN_LEN == 1);
`ifdef DAC_LDAC_EN
              ldac_q  <= 1'b0;
`endif
              state_q <= FIN;
            end else begin
              sclk_q <= 1'b0;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        FIN: begin
`ifdef DAC_LDAC_EN
          if (int'(fin_q) == CLK_DIV - 1) ldac_q <= 1'b1;
`endif
          if (fin_end) begin
            busy_q  <= 1'b0;
            state_q <= INICIO;
          end else begin
            fin_q  <= fin_q + FIN_W'(1);
            tick_q <= fin_pre;
          end
        end

        default: begin
          state_q <= INICIO;
          cs_q    <= 1'b1;
          sclk_q  <= 1'b1;
          sdata_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CS           = cs_q;
  assign bus.SCLK         = sclk_q;
  assign bus.SDATA        = sdata_q;
  assign bus.busy         = busy_q;
  assign bus.tx_done_tick = tick_q;
`ifdef DAC_LDAC_EN
  assign bus.LDAC_n       = ldac_q;
`endif

endmodule

// File: tb/tb_dac_transmision.sv
// -----------------------------------------------------------------------------
// tb_dac_transmision
//   Scoreboard bench for dac_transmision (CLK_DIV=2, CS_IDLE_CYCLES=4).
//   Stimulus pushes the expected 16-bit frame word into exp_q. A monitor
//   process samples on the falling clk edge. It captures SDATA on every
//   falling SCLK edge and pops and compares a word each time CS rises.
//   Cycle indices are counts of rising clk edges.
// -----------------------------------------------------------------------------
module tb_dac_transmision;
  localparam int CD   = 2;
  localparam int IDLE = 4;
`ifdef DAC_LDAC_EN
  localparam int FIN_LEN = CD + IDLE;
`else
  localparam int FIN_LEN = IDLE;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  dac_transmision_if bus();

  dac_transmision #(.CLK_DIV(CD), .CS_IDLE_CYCLES(IDLE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [15:0] exp_q[$];

  // ---------------- monitor / scoreboard ----------------
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [15:0] sh = '0;
  int          nb = 0, frames = 0, ticks = 0;
  int          cs_fall_cyc = 0, cs_rise_cyc = 0, period_last = 0;
  bit          live = 0, has_rise = 0, has_fall = 0, busy_next = 0;
  int          ldac_cnt = 0, ldac_first = -1;

  always @(negedge clk) begin
    if (!reset_n) begin
      live = 0; nb = 0; prev_cs = 1'b1; prev_sclk = 1'b1;
      has_rise = 0; has_fall = 0; busy_next = 0;
    end else begin
      if (busy_next) begin
        check("busy_low_after_tick", 32'(bus.busy), 32'd0);
        busy_next = 0;
      end
      if (prev_cs && !bus.CS) begin
        if (has_rise) check("cs_high_gap_min", 32'((cyc - cs_rise_cyc) >= IDLE), 32'd1);
        if (has_fall) period_last = cyc - cs_fall_cyc;
        has_fall = 1;
        live = 1; nb = 0; cs_fall_cyc = cyc;
        ldac_cnt = 0; ldac_first = -1;
      end
      if (live && !bus.CS && prev_sclk && !bus.SCLK) begin
        sh = {sh[14:0], bus.SDATA};
        nb++;
      end
      if (live && !prev_cs && bus.CS) begin
        live = 0; has_rise = 1; cs_rise_cyc = cyc; frames++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(sh), 32'hFFFF_FFFF);
        end else begin
          check("frame_bits", 32'(sh), 32'(exp_q.pop_front()));
          check("falling_edges", 32'(nb), 32'd16);
          check("cs_low_cycles", 32'(cyc - cs_fall_cyc), 32'(33 * CD));
        end
      end
`ifdef DAC_LDAC_EN
      if (!bus.LDAC_n) begin
        if (ldac_first < 0) ldac_first = cyc;
        ldac_cnt++;
      end
`endif
      if (bus.tx_done_tick) begin
        ticks++;
        // The edge FIN_LEN after the CS-rising edge samples tick high.
        check("tick_after_cs_rise", 32'(cyc - cs_rise_cyc + 1), 32'(FIN_LEN));
        check("busy_at_tick", 32'(bus.busy), 32'd1);
        busy_next = 1;
`ifdef DAC_LDAC_EN
        check("ldac_low_cycles", 32'(ldac_cnt), 32'(CD));
        check("ldac_start", 32'(ldac_first - cs_rise_cyc), 32'd0);
`endif
      end
      prev_cs = bus.CS; prev_sclk = bus.SCLK;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [3:0] c, input logic [11:0] d, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("send_wait_timeout", 32'd1, 32'd0);
    bus.tx_start = 1'b1; bus.ctrl_in = c; bus.data_in = d;
    if (push) exp_q.push_back({c, d});
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.busy == 1'b0 && bus.CS == 1'b1) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_bits(input int k);
    int n;
    n = 0;
    do begin @(posedge clk); n++; end while (nb < k && n < 300);
    if (n >= 300) check("edge_wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_CS"},    32'(bus.CS),           32'd1);
    check({tag, "_SCLK"},  32'(bus.SCLK),         32'd1);
    check({tag, "_SDATA"}, 32'(bus.SDATA),        32'd0);
    check({tag, "_busy"},  32'(bus.busy),         32'd0);
    check({tag, "_tick"},  32'(bus.tx_done_tick), 32'd0);
`ifdef DAC_LDAC_EN
    check({tag, "_LDAC"},  32'(bus.LDAC_n),       32'd1);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, t0, n;
    bus.tx_start = 1'b0; bus.ctrl_in = '0; bus.data_in = '0;

    // 1. Asynchronous reset before any clk edge.
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2. Single frame.
    f0 = frames; t0 = ticks;
    send(4'h3, 12'hA5C, 1);
    wait_idle();
    repeat (10) @(negedge clk);
    check("single_frames", 32'(frames - f0), 32'd1);
    check("single_ticks",  32'(ticks - t0),  32'd1);

    // 3. A request during a frame is ignored.
    f0 = frames; t0 = ticks;
    send(4'h0, 12'h000, 1);
    wait_bits(8);
    @(negedge clk);
    bus.tx_start = 1'b1; bus.data_in = 12'hFFF;
    @(negedge clk);
    bus.tx_start = 1'b0; bus.data_in = 12'h000;
    wait_idle();
    repeat (150) @(negedge clk);
    check("reject_frames", 32'(frames - f0), 32'd1);
    check("reject_ticks",  32'(ticks - t0),  32'd1);

    // 4. tx_start held high: back-to-back frames.
    f0 = frames; t0 = ticks;
    @(negedge clk);
    bus.tx_start = 1'b1; bus.ctrl_in = 4'h0; bus.data_in = 12'h001;
    exp_q.push_back(16'h0001);
    n = 0;
    while (!bus.busy && n < 10) begin @(negedge clk); n++; end
    bus.data_in = 12'h800;
    exp_q.push_back(16'h0800);
    n = 0;
    while (bus.busy && n < 300) begin @(negedge clk); n++; end
    n = 0;
    while (!bus.busy && n < 10) begin @(negedge clk); n++; end
    bus.tx_start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    check("b2b_frames", 32'(frames - f0), 32'd2);
    check("b2b_ticks",  32'(ticks - t0),  32'd2);
    check("b2b_period", 32'(period_last), 32'(33 * CD + FIN_LEN + 1));

    // 5. Reset aborts a frame after falling edge 5.
    t0 = ticks;
    send(4'h0, 12'h555, 0);
    wait_bits(5);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_ticks", 32'(ticks - t0), 32'd0);
    f0 = frames; t0 = ticks;
    send(4'h0, 12'h123, 1);
    wait_idle();
    repeat (10) @(negedge clk);
    check("after_abort_frames", 32'(frames - f0), 32'd1);
    check("after_abort_ticks",  32'(ticks - t0),  32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
